// File: rtl/regfile_dump.sv
// regfile_dump: post-run register-file dump sequencer.
// Lets the processor run for RUN_CYCLES cycles after start. It then freezes the
// processor, takes over regfile read port A, and streams every register as an
// {index, value} beat over a valid/ready handshake.
// Optional feature macro: REGDUMP_SKIP_R0_EN (defined: r0 is not dumped, the scan
// covers indices 1..31).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start, processor owns read port A
// S_RUN     | processor running, cycle_count advancing
// S_SCAN_ADDR| processor held, scan index driven onto read port A
// S_SCAN_OUT| beat presented, waiting for dump_ready
// S_DONE    | dump complete, processor still held, start re-arms
module regfile_dump #(
    parameter int RUN_CYCLES = 255,
    parameter int CNT_W      = 8
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [4:0]       cpu_rs1_i,
    output logic [4:0]       rs1_out_o,
    input  logic [31:0]      reg_data_i,
    output logic             cpu_hold_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [4:0]       dump_idx_o,
    output logic [31:0]      dump_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN_ADDR,
        S_SCAN_OUT,
        S_DONE
    } state_e;

`ifdef REGDUMP_SKIP_R0_EN
    localparam logic [4:0] FIRST_IDX = 5'd1;
`else
    localparam logic [4:0] FIRST_IDX = 5'd0;
`endif
    localparam logic [4:0]       LAST_IDX = 5'd31;
    // With no run phase the compare value is never used.
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               NO_RUN   = (RUN_CYCLES == 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic [4:0]        scan_idx_q;
    logic              dump_valid_q;
    logic [4:0]        dump_idx_q;
    logic [31:0]       dump_data_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= S_IDLE;
            cycle_count_q <= '0;
            scan_idx_q    <= FIRST_IDX;
            dump_valid_q  <= 1'b0;
            dump_idx_q    <= 5'd0;
            dump_data_q   <= 32'd0;
            cpu_hold_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        cycle_count_q <= '0;
                        scan_idx_q    <= FIRST_IDX;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        if (NO_RUN) begin
                            state_q    <= S_SCAN_ADDR;
                            cpu_hold_q <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            cpu_hold_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_q + CNT_ONE;
                    if (cycle_count_q == RUN_LAST) begin
                        state_q    <= S_SCAN_ADDR;
                        cpu_hold_q <= 1'b1;
                    end
                end
                S_SCAN_ADDR: begin
                    dump_data_q  <= reg_data_i;
                    dump_idx_q   <= scan_idx_q;
                    dump_valid_q <= 1'b1;
                    state_q      <= S_SCAN_OUT;
                end
                S_SCAN_OUT: begin
                    if (dump_ready_i) begin
                        dump_valid_q <= 1'b0;
                        if (scan_idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            scan_idx_q <= scan_idx_q + 5'd1;
                            state_q    <= S_SCAN_ADDR;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read port A belongs to the processor until the dump takes it over.
    assign rs1_out_o = (state_q == S_IDLE || state_q == S_RUN) ? cpu_rs1_i : scan_idx_q;

    assign cpu_hold_o    = cpu_hold_q;
    assign dump_valid_o  = dump_valid_q;
    assign dump_idx_o    = dump_idx_q;
    assign dump_data_o   = dump_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: one instance with RUN_CYCLES=10, one with RUN_CYCLES=0.
// Regfile model holds rN = N*3.
module tb_regfile_dump;

`ifdef REGDUMP_SKIP_R0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NB = 32 - FIRST;
    localparam int RC = 10;
    localparam logic [4:0] CPU_RS1 = 5'd9;

    logic        clk;
    logic        rst_n;
    logic        start, start0;
    logic        ready, ready0;
    logic [4:0]  rs1_out, rs1_out0;
    logic [31:0] reg_data, reg_data0;
    logic        hold, hold0;
    logic        valid, valid0;
    logic [4:0]  idx, idx0;
    logic [31:0] data, data0;
    logic        busy, busy0;
    logic        done, done0;
    logic [7:0]  count, count0;
    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    regfile_dump #(.RUN_CYCLES(RC), .CNT_W(8)) dut (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start), .cpu_rs1_i(CPU_RS1),
        .rs1_out_o(rs1_out), .reg_data_i(reg_data), .cpu_hold_o(hold),
        .dump_valid_o(valid), .dump_ready_i(ready), .dump_idx_o(idx),
        .dump_data_o(data), .busy_o(busy), .done_o(done), .cycle_count_o(count)
    );

    regfile_dump #(.RUN_CYCLES(0), .CNT_W(8)) dut0 (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start0), .cpu_rs1_i(CPU_RS1),
        .rs1_out_o(rs1_out0), .reg_data_i(reg_data0), .cpu_hold_o(hold0),
        .dump_valid_o(valid0), .dump_ready_i(ready0), .dump_idx_o(idx0),
        .dump_data_o(data0), .busy_o(busy0), .done_o(done0), .cycle_count_o(count0)
    );

    assign reg_data  = rf[rs1_out];
    assign reg_data0 = rf[rs1_out0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and run until cpu_hold rises; optionally re-pulse start at a RUN count.
    task automatic run_to_hold(input int ign_at);
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("run_busy", busy, 1);
        check_eq("run_cnt0", count, 0);
        check_eq("run_hold0", hold, 0);
        check_eq("run_done0", done, 0);
        check_eq("run_rs1", rs1_out, CPU_RS1);
        n = 0;
        while (!hold && n < 100) begin
            start = (n == ign_at);
            step();
            n++;
        end
        start = 1'b0;
        check_eq("hold_cycles", n, RC);
        check_eq("cnt_end", count, RC);
        check_eq("scan_rs1", rs1_out, FIRST);
    endtask

    // Collect all beats from cpu_hold rise to done; stall beat stall_idx for 5 cycles.
    task automatic run_dump(input int stall_idx);
        int c, b, stall;
        c = 0; b = 0; stall = 0;
        ready = 1'b1;
        while (!done && c < 400) begin
            if (valid) begin
                if (int'(idx) == stall_idx && stall < 5) begin
                    ready = 1'b0;
                    check_eq("bp_idx", idx, FIRST + b);
                    check_eq("bp_data", data, 3 * (FIRST + b));
                    stall++;
                end else begin
                    ready = 1'b1;
                    check_eq("beat_idx", idx, FIRST + b);
                    check_eq("beat_data", data, 3 * (FIRST + b));
                    b++;
                end
            end else begin
                ready = 1'b1;
            end
            step();
            c++;
        end
        check_eq("beats", b, NB);
        check_eq("dump_cycles", c, 2 * NB + ((stall_idx >= 0) ? 5 : 0));
        check_eq("done_hi", done, 1);
        check_eq("busy_done", busy, 0);
        check_eq("hold_done", hold, 1);
        check_eq("valid_done", valid, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; ready = 1'b1; ready0 = 1'b0;
        step();
        step();
        check_eq("rst_valid", valid, 0);
        check_eq("rst_idx", idx, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_hold", hold, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", count, 0);
        check_eq("idle_rs1", rs1_out, CPU_RS1);
        rst_n = 1'b1;
        step();

        // RUN_CYCLES=0 instance: first beat two cycles after start
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check_eq("rc0_hold", hold0, 1);
        check_eq("rc0_busy", busy0, 1);
        check_eq("rc0_valid_early", valid0, 0);
        step();
        check_eq("rc0_valid", valid0, 1);
        check_eq("rc0_idx", idx0, FIRST);
        check_eq("rc0_data", data0, 3 * FIRST);
        check_eq("rc0_cnt", count0, 0);

        // Basic run with ignored start at count 3 and backpressure on beat 4
        run_to_hold(3);
        run_dump(4);
        step();
        check_eq("done_stays", done, 1);

        // Restart from DONE: full new dump
        run_to_hold(-1);
        run_dump(-1);

        // Reset in the middle of the scan, on beat 7
        run_to_hold(-1);
        n = 0;
        while (!(valid && idx == 5'd7) && n < 100) begin
            ready = 1'b1;
            step();
            n++;
        end
        ready = 1'b0;
        check_eq("reach_idx7", (valid && idx == 5'd7), 1);
        step();
        check_eq("idx7_held", idx, 7);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_idx", idx, 0);
        check_eq("mid_rst_cnt", count, 0);
        check_eq("mid_rst_hold", hold, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rs1", rs1_out, CPU_RS1);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        step();
        run_to_hold(-1);
        run_dump(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
